// File: rtl/crc8_frame_appender.sv
// Streaming framer: forwards payload bytes unchanged and appends a CRC-8
// byte (MSB-first, no reflection, no final XOR) after the last byte of
// every frame. One registered output stage; the CRC byte carries m_last_o.
module crc8_frame_appender #(
  parameter logic [7:0] POLYNOMIAL = 8'h07,
  parameter logic [7:0] INIT       = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  // payload input stream
  input  logic [7:0] s_data_i,
  input  logic       s_valid_i,
  input  logic       s_last_i,
  output logic       s_ready_o,
  // framed output stream
  output logic [7:0] m_data_o,
  output logic       m_valid_o,
  output logic       m_last_o,
  input  logic       m_ready_i,
  // frame in flight
  output logic       busy_o
);

  localparam int unsigned DATA_W = 8;

  localparam logic [0:0] ST_PAYLOAD = 1'b0;
  localparam logic [0:0] ST_CRC     = 1'b1;

  // One CRC-8 byte update: fold the byte in, then eight shift/XOR steps.
  function automatic logic [DATA_W-1:0] crc8_next(input logic [DATA_W-1:0] crc,
                                                  input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] x;
    x = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      if (x[7]) begin
        x = {x[6:0], 1'b0} ^ POLYNOMIAL;
      end else begin
        x = {x[6:0], 1'b0};
      end
    end
    return x;
  endfunction

  logic [0:0]        state_q,  state_d;
  logic [DATA_W-1:0] crc_q,    crc_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q,  m_last_d;
  logic              busy_q,    busy_d;

  logic slot_free_c;
  logic s_ready_c;
  logic in_xfer_c;
  logic crc_accept_c;

  // Handshake qualifiers: output slot availability and input acceptance.
  always_comb begin
    slot_free_c  = !m_valid_q || m_ready_i;
    s_ready_c    = (state_q == ST_PAYLOAD) && slot_free_c;
    in_xfer_c    = s_valid_i && s_ready_c;
    crc_accept_c = m_valid_q && m_last_q && m_ready_i;
  end

  // Next-state, CRC and output-register update.
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    busy_d    = busy_q;

    // Drained byte with nothing new to load empties the slot.
    if (m_ready_i) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    case (state_q)
      ST_PAYLOAD: begin
        if (in_xfer_c) begin
          m_data_d  = s_data_i;
          m_valid_d = 1'b1;
          m_last_d  = 1'b0;
          crc_d     = crc8_next(crc_q, s_data_i);
          if (s_last_i) begin
            state_d = ST_CRC;
          end
        end
      end
      ST_CRC: begin
        // crc_q already covers the last payload byte.
        if (slot_free_c) begin
          m_data_d  = crc_q;
          m_valid_d = 1'b1;
          m_last_d  = 1'b1;
          crc_d     = INIT;
          state_d   = ST_PAYLOAD;
        end
      end
      default: begin
        state_d = ST_PAYLOAD;
      end
    endcase

    // Busy ends when the CRC byte leaves; a new frame's first byte re-arms it.
    if (crc_accept_c) begin
      busy_d = 1'b0;
    end
    if (in_xfer_c) begin
      busy_d = 1'b1;
    end
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_PAYLOAD;
      crc_q     <= INIT;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      busy_q    <= busy_d;
    end
  end

  assign s_ready_o = s_ready_c;
  assign m_data_o  = m_data_q;
  assign m_valid_o = m_valid_q;
  assign m_last_o  = m_last_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_crc8_frame_appender.sv
// Directed bench for crc8_frame_appender: hand-computed CRC-8 (poly 0x07)
// expectations for single-byte, check-string, back-to-back, stall and reset cases.
module tb_crc8_frame_appender;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready_o;
  logic [7:0] m_data_o;
  logic       m_valid_o;
  logic       m_last_o;
  logic       m_ready_man;
  logic       rand_en;
  logic [7:0] lfsr = 8'hA5;
  logic       m_ready;
  logic       busy_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Output beats observed on the stream.
  logic [7:0] out_data[$];
  logic       out_last[$];
  int         out_cyc[$];
  int         stab_err   = 0;
  int         sready_err = 0;

  logic [7:0] prev_d;
  logic       prev_l;
  logic       prev_v = 1'b0;
  logic       prev_r = 1'b0;

  logic [7:0] check_str [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                                8'h36, 8'h37, 8'h38, 8'h39};

  assign m_ready = rand_en ? lfsr[0] : m_ready_man;

  crc8_frame_appender dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .s_data_i (s_data),
    .s_valid_i(s_valid),
    .s_last_i (s_last),
    .s_ready_o(s_ready_o),
    .m_data_o (m_data_o),
    .m_valid_o(m_valid_o),
    .m_last_o (m_last_o),
    .m_ready_i(m_ready),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pseudo-random ready pattern, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // Stream monitor: records beats and tracks stall stability / ready rule.
  always @(negedge clk) begin
    if (!rst_ni) begin
      prev_v = 1'b0;
      prev_r = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        if (!(m_valid_o && m_data_o == prev_d && m_last_o == prev_l)) stab_err++;
      end
      if (m_valid_o && !m_ready && s_ready_o) sready_err++;
      if (m_valid_o && m_ready) begin
        out_data.push_back(m_data_o);
        out_last.push_back(m_last_o);
        out_cyc.push_back(cyc);
      end
      prev_v = m_valid_o;
      prev_r = m_ready;
      prev_d = m_data_o;
      prev_l = m_last_o;
    end
  end

  // Present one byte (after optional idle gap) and return once it is accepted.
  task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
    logic acc;
    acc = 1'b0;
    s_valid = 1'b0;
    repeat (gap) begin
      s_data = 8'($urandom);
      s_last = 1'($urandom);
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = b;
    s_last  = last;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      acc = s_ready_o;
      @(posedge clk); #1;
    end
    if (!acc) begin
      total++; bad++;
      $display("FAIL send_byte timeout: byte %h not accepted (got no ready, required ready)", b);
    end
    s_valid = 1'b0;
    s_data  = 8'hA5;
    s_last  = 1'b1;
  endtask

  // Wait (bounded) until n beats have been observed since index idx0.
  task automatic wait_beats(input int idx0, input int n, input string name);
    int i;
    i = 0;
    while (out_data.size() < idx0 + n && i < 1000) begin
      @(negedge clk);
      i++;
    end
    total++;
    if (out_data.size() < idx0 + n) begin
      bad++;
      $display("FAIL %s beat count: got %0d required %0d", name, out_data.size() - idx0, n);
    end
  endtask

  task automatic test_reset();
    rst_ni      = 1'b0;
    s_valid     = 1'b0;
    s_data      = 8'h00;
    s_last      = 1'b0;
    m_ready_man = 1'b1;
    rand_en     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({m_valid_o, m_last_o, m_data_o, busy_o} !== 11'h000) begin
      bad++;
      $display("FAIL reset outputs: got v=%b l=%b d=%h busy=%b required all 0",
               m_valid_o, m_last_o, m_data_o, busy_o);
    end
    total++;
    if (s_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset s_ready: got %b required 1", s_ready_o);
    end
    rst_ni = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int idx0;
    int busy_cnt;
    logic [7:0] exp_d [2] = '{8'h01, 8'h07};
    logic       exp_l [2] = '{1'b0, 1'b1};
    idx0 = out_data.size();
    busy_cnt = 0;
    send_byte(8'h01, 1'b1, 0);
    repeat (6) begin
      @(negedge clk);
      if (busy_o === 1'b1) busy_cnt++;
    end
    @(posedge clk); #1;
    wait_beats(idx0, 2, "single");
    for (int i = 0; i < 2; i++) begin
      if (out_data.size() > idx0 + i) begin
        total++;
        if (out_data[idx0+i] !== exp_d[i] || out_last[idx0+i] !== exp_l[i]) begin
          bad++;
          $display("FAIL single beat %0d: got %h/%b required %h/%b", i,
                   out_data[idx0+i], out_last[idx0+i], exp_d[i], exp_l[i]);
        end
      end
    end
    if (out_data.size() >= idx0 + 2) begin
      total++;
      if (out_cyc[idx0+1] - out_cyc[idx0] !== 1) begin
        bad++;
        $display("FAIL single spacing: got %0d cycles required 1", out_cyc[idx0+1] - out_cyc[idx0]);
      end
    end
    total++;
    if (busy_cnt !== 2) begin
      bad++;
      $display("FAIL single busy cycles: got %0d required 2", busy_cnt);
    end
  endtask

  task automatic test_check_string();
    int idx0;
    idx0 = out_data.size();
    for (int i = 0; i < 9; i++) send_byte(check_str[i], i == 8, 0);
    wait_beats(idx0, 10, "string");
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    if (out_data.size() >= idx0 + 10) begin
      for (int i = 0; i < 10; i++) begin
        total++;
        if (out_data[idx0+i] !== ((i < 9) ? check_str[i] : 8'hF4) ||
            out_last[idx0+i] !== (i == 9)) begin
          bad++;
          $display("FAIL string beat %0d: got %h/%b required %h/%b", i, out_data[idx0+i],
                   out_last[idx0+i], (i < 9) ? check_str[i] : 8'hF4, i == 9);
        end
      end
      total++;
      if (out_cyc[idx0+9] - out_cyc[idx0] !== 9) begin
        bad++;
        $display("FAIL string throughput: got %0d cycles span required 9",
                 out_cyc[idx0+9] - out_cyc[idx0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int idx0;
    logic [7:0] exp_d [4] = '{8'hFF, 8'hF3, 8'h00, 8'h00};
    logic       exp_l [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    idx0 = out_data.size();
    send_byte(8'hFF, 1'b1, 0);
    send_byte(8'h00, 1'b1, 0);
    wait_beats(idx0, 4, "b2b");
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      if (out_data.size() > idx0 + i) begin
        total++;
        if (out_data[idx0+i] !== exp_d[i] || out_last[idx0+i] !== exp_l[i]) begin
          bad++;
          $display("FAIL b2b beat %0d: got %h/%b required %h/%b", i,
                   out_data[idx0+i], out_last[idx0+i], exp_d[i], exp_l[i]);
        end
      end
    end
    if (out_data.size() >= idx0 + 4) begin
      total++;
      if (out_cyc[idx0+3] - out_cyc[idx0] !== 3) begin
        bad++;
        $display("FAIL b2b spacing: got %0d cycles span required 3", out_cyc[idx0+3] - out_cyc[idx0]);
      end
    end
  endtask

  task automatic test_random_stall();
    int idx0;
    idx0 = out_data.size();
    rand_en = 1'b1;
    for (int i = 0; i < 9; i++) send_byte(check_str[i], i == 8, int'($urandom_range(0, 2)));
    wait_beats(idx0, 10, "stall");
    rand_en = 1'b0;
    @(posedge clk); #1;
    if (out_data.size() >= idx0 + 10) begin
      for (int i = 0; i < 10; i++) begin
        total++;
        if (out_data[idx0+i] !== ((i < 9) ? check_str[i] : 8'hF4) ||
            out_last[idx0+i] !== (i == 9)) begin
          bad++;
          $display("FAIL stall beat %0d: got %h/%b required %h/%b", i, out_data[idx0+i],
                   out_last[idx0+i], (i < 9) ? check_str[i] : 8'hF4, i == 9);
        end
      end
    end
    total++;
    if (stab_err !== 0) begin
      bad++;
      $display("FAIL stall stability: got %0d unstable cycles required 0", stab_err);
    end
    total++;
    if (sready_err !== 0) begin
      bad++;
      $display("FAIL stall s_ready: got %0d cycles ready while blocked required 0", sready_err);
    end
  endtask

  task automatic test_long_hold();
    int idx0;
    int hold_bad;
    idx0 = out_data.size();
    hold_bad = 0;
    m_ready_man = 1'b0;
    send_byte(check_str[0], 1'b0, 0);
    s_valid = 1'b1;
    s_data  = check_str[1];
    s_last  = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (m_valid_o !== 1'b1 || m_data_o !== check_str[0] || s_ready_o !== 1'b0) hold_bad++;
    end
    total++;
    if (hold_bad !== 0) begin
      bad++;
      $display("FAIL hold: got %0d bad cycles (v=%b d=%h rdy=%b) required 0 (v=1 d=31 rdy=0)",
               hold_bad, m_valid_o, m_data_o, s_ready_o);
    end
    total++;
    if (out_data.size() !== idx0) begin
      bad++;
      $display("FAIL hold beats: got %0d required 0", out_data.size() - idx0);
    end
    @(posedge clk); #1;
    m_ready_man = 1'b1;
    for (int i = 1; i < 9; i++) send_byte(check_str[i], i == 8, 0);
    wait_beats(idx0, 10, "hold");
    @(posedge clk); #1;
    if (out_data.size() >= idx0 + 10) begin
      for (int i = 0; i < 10; i++) begin
        total++;
        if (out_data[idx0+i] !== ((i < 9) ? check_str[i] : 8'hF4) ||
            out_last[idx0+i] !== (i == 9)) begin
          bad++;
          $display("FAIL hold beat %0d: got %h/%b required %h/%b", i, out_data[idx0+i],
                   out_last[idx0+i], (i < 9) ? check_str[i] : 8'hF4, i == 9);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int idx0;
    int n_last;
    idx0 = out_data.size();
    for (int i = 0; i < 4; i++) send_byte(check_str[i], 1'b0, 0);
    #2;
    rst_ni = 1'b0;
    #1;
    total++;
    if (m_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL async reset: got v=%b busy=%b required 0/0", m_valid_o, busy_o);
    end
    @(posedge clk); #1;
    rst_ni = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_last = 0;
    for (int i = idx0; i < out_data.size(); i++) if (out_last[i]) n_last++;
    total++;
    if (out_data.size() - idx0 !== 3 || n_last !== 0) begin
      bad++;
      $display("FAIL reset partial frame: got %0d beats %0d last required 3 beats 0 last",
               out_data.size() - idx0, n_last);
    end
    idx0 = out_data.size();
    for (int i = 0; i < 9; i++) send_byte(check_str[i], i == 8, 0);
    wait_beats(idx0, 10, "postreset");
    @(posedge clk); #1;
    if (out_data.size() >= idx0 + 10) begin
      total++;
      if (out_data[idx0+9] !== 8'hF4 || out_last[idx0+9] !== 1'b1) begin
        bad++;
        $display("FAIL postreset crc: got %h/%b required f4/1", out_data[idx0+9], out_last[idx0+9]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_check_string();
    test_back_to_back();
    test_random_stall();
    test_long_hold();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crc8_frame_appender.md
Name: crc8_frame_appender

Overview:
Streaming framer that sits directly upstream of the byte-link output. It accepts payload bytes on a valid/ready input stream and forwards them unchanged. It computes a running CRC-8 over the forwarded bytes and appends one CRC byte after the last payload byte of each frame. The output stream carries payload bytes, then the CRC byte flagged as last. A receiver running the same CRC-8 over the whole frame, CRC byte included, therefore ends at 0x00 when INIT is 0x00.

Parameters:
POLYNOMIAL, 8'h07, CRC-8 generator polynomial, MSB-first, implicit x^8 term.
INIT, 8'h00, CRC register value at reset and at the start of every frame.

Ports:
clk_i  input  1  single clock; all logic on its rising edge.
rst_ni  input  1  asynchronous, active-low reset.
s_data_i  input  8  payload byte.
s_valid_i  input  1  payload byte valid.
s_last_i  input  1  final payload byte of the frame; qualified by s_valid_i.
s_ready_o  output  1  appender accepts the payload byte this cycle.
m_data_o  output  8  output byte (payload or CRC).
m_valid_o  output  1  output byte valid.
m_last_o  output  1  output byte is the appended CRC byte; qualified by m_valid_o.
m_ready_i  input  1  downstream accepts the output byte.
busy_o  output  1  high from the first accepted payload byte until the CRC byte is accepted.

Behaviour:
- Reset (rst_ni low, asynchronous): state=PAYLOAD, crc=INIT, m_valid_o=0, m_last_o=0, m_data_o=0, busy_o=0. s_ready_o then follows the PAYLOAD rule.
- CRC step: crc' = next(crc, b) where x = crc ^ b, then 8 iterations of: shift left; if the bit shifted out is 1, XOR with POLYNOMIAL. No reflection, no final XOR.
- Output register: one stage; m_* are registers. slot_free = !m_valid_o || m_ready_i.
- Handshakes: a transfer occurs when valid && ready. m_valid_o, m_data_o and m_last_o stay stable while m_valid_o=1 and m_ready_i=0. s_ready_o may depend combinationally on m_ready_i; nothing depends combinationally on s_valid_i.
- State PAYLOAD:
  - s_ready_o = slot_free.
  - On an input transfer: m_data_o<=s_data_i, m_valid_o<=1, m_last_o<=0, crc<=next(crc, s_data_i), busy_o<=1.
  - If s_last_i is also set: state<=CRC.
- State CRC:
  - s_ready_o = 0.
  - When slot_free: m_data_o<=crc (already includes the last payload byte), m_valid_o<=1, m_last_o<=1, crc<=INIT, state<=PAYLOAD.
  - busy_o clears when that CRC byte is accepted.
- Any state: if m_ready_i is high and no new byte loads this cycle, m_valid_o<=0 and m_last_o<=0.
- Latency: payload byte appears on m_* the cycle after acceptance.
- Throughput: with m_ready_i held high, an N-byte frame takes N+1 output cycles. The first byte of the next frame is accepted in the cycle after the CRC byte is loaded; there is no gap beyond the CRC slot.
- One-byte frame (s_last_i on the first byte) is legal: output is payload then CRC.
- A frame with zero payload bytes cannot be expressed; an empty frame produces no output.
- Backpressure with m_ready_i low indefinitely: at most one byte is held; s_ready_o=0; no data is lost or duplicated.
- Reset mid-frame: the partial frame is discarded with no CRC byte. The first byte accepted after reset starts a fresh CRC from INIT.
- s_data_i and s_last_i are ignored when s_valid_i=0.

Test Plan:
- Single byte 0x01, s_last_i=1, m_ready_i=1, defaults -> output 0x01 (last=0) then 0x07 (last=1) on consecutive cycles; busy_o high for exactly those 2 cycles.
- ASCII "123456789" streamed back-to-back with last on '9', m_ready_i=1 -> the 9 bytes unchanged then 0xF4 with m_last_o=1; 10 output beats in 10 consecutive cycles.
- Two frames back-to-back, [0xFF] then [0x00], m_ready_i=1 -> FF, F3(last), 00, 00(last); proves the CRC reinitialises to INIT between frames.
- "123456789" with m_ready_i toggled by a pseudo-random pattern and s_valid_i gaps -> identical byte sequence ending with 0xF4; m_* stable while stalled; s_ready_o=0 whenever the slot is occupied and not draining.
- m_ready_i=0 for 20 cycles after the first byte -> m_data_o holds the first byte, m_valid_o=1 and s_ready_o=0 throughout; releasing m_ready_i resumes the frame with no loss.
- rst_ni pulsed low asynchronously after 4 bytes of "123456789" -> m_valid_o drops immediately and no CRC byte is emitted; a new frame "123456789" then yields 0xF4.
